// File: rtl/qch_pkg.sv
// Shared types for the Q-channel power sequencer: FSM state encoding and
// the per-channel handshake status decode.
package qch_pkg;

    typedef enum logic [3:0] {
        ST_RUN     = 4'd0,
        ST_REQ     = 4'd1,
        ST_ABORT   = 4'd2,
        ST_ISO     = 4'd3,
        ST_SAVE    = 4'd4,
        ST_OFF     = 4'd5,
        ST_PWRUP   = 4'd6,
        ST_RESTORE = 4'd7,
        ST_EXIT    = 4'd8
    } state_e;

    typedef struct packed {
        logic run;
        logic acc;
        logic den;
    } ch_status_t;

    function automatic ch_status_t ch_status(input logic qacceptn, input logic qdeny);
        ch_status_t s;
        s.run = qacceptn & ~qdeny;
        s.acc = ~qacceptn & ~qdeny;
        s.den = qdeny;
        return s;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/qch_chan.sv
// One Q-channel request flop. qreqn may only fall while the device is in
// RUN and may only rise once the device has resolved (qacceptn == qdeny).
module qch_chan
    import qch_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       lower_i,
    input  logic       raise_i,
    input  logic       qacceptn_i,
    input  logic       qdeny_i,
    output logic       qreqn_o,
    output ch_status_t status_o
);

    logic qreqn_q, qreqn_d;

    always_comb begin
        status_o = ch_status(qacceptn_i, qdeny_i);
        qreqn_d  = qreqn_q;
        if (lower_i && status_o.run)
            qreqn_d = 1'b0;
        else if (raise_i && (qacceptn_i == qdeny_i))
            qreqn_d = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) qreqn_q <= 1'b1;
        else         qreqn_q <= qreqn_d;
    end

    assign qreqn_o = qreqn_q;

endmodule

// File: rtl/qch_pwr_ctrl.sv
// Controller-side Q-channel power sequencer: quiesces NUM_CH devices, then
// isolates, saves and powers off the domain; wake reverses the sequence.
module qch_pwr_ctrl
    import qch_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int SAVE_CYCLES  = 2,
    parameter int PWRUP_CYCLES = 8,
    parameter int TIMEOUT      = 1024,
    parameter int CNT_W        = $clog2(max3(SAVE_CYCLES, PWRUP_CYCLES, TIMEOUT) + 1)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              pm_sleep_req,
    input  logic              pm_wake_req,
    output logic [NUM_CH-1:0] qreqn,
    input  logic [NUM_CH-1:0] qacceptn,
    input  logic [NUM_CH-1:0] qdeny,
    output logic              iso_en,
    output logic              pwr_en,
    output logic              pr_save,
    output logic              pr_restore,
    output logic [3:0]        pm_state,
    output logic              pm_done,
    output logic              pm_denied,
    output logic              timeout_err
);

    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SAVE_LAST  = CNT_W'(SAVE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_CH-1:0]  en_q, en_d;
    logic [NUM_CH-1:0]  run_v, acc_v, den_v, qreqn_v;
    logic               go, raise_req, tout_set;
    logic               iso_q, pwr_q, save_q, restore_q, done_q, denied_q, tout_q;
    logic               sleep_ok, all_acc, all_run, any_den;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ch_status_t st;
        qch_chan u_chan (
            .clk        (clk),
            .resetn     (resetn),
            .lower_i    (go & ch_en[i]),
            .raise_i    (raise_req & en_q[i]),
            .qacceptn_i (qacceptn[i]),
            .qdeny_i    (qdeny[i]),
            .qreqn_o    (qreqn_v[i]),
            .status_o   (st)
        );
        assign run_v[i] = st.run;
        assign acc_v[i] = st.acc;
        assign den_v[i] = st.den;
    end

    // Disabled channels count as satisfied in every "all" test.
    assign sleep_ok = &(run_v | ~ch_en);
    assign all_acc  = &(acc_v | ~en_q);
    assign all_run  = &(run_v | ~en_q);
    assign any_den  = |(den_v & en_q);

    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        go       = 1'b0;
        tout_set = 1'b0;
        case (state_q)
            ST_RUN: if (pm_sleep_req && sleep_ok) begin
                go      = 1'b1;
                en_d    = ch_en;
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (all_acc)
                    state_d = ST_ISO;
                else if (any_den)
                    state_d = ST_ABORT;
                else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                    state_d  = ST_ABORT;
                    tout_set = 1'b1;
                end
            end
            ST_ABORT:   if (all_run && (&qreqn_v)) state_d = ST_RUN;
            ST_ISO:     state_d = ST_SAVE;
            ST_SAVE:    if (cnt_q == SAVE_LAST) state_d = ST_OFF;
            ST_OFF:     if (pm_wake_req) state_d = ST_PWRUP;
            ST_PWRUP:   if (cnt_q == PWRUP_LAST) state_d = ST_RESTORE;
            ST_RESTORE: state_d = ST_EXIT;
            ST_EXIT:    if (all_run) state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase
        cnt_d     = (state_d != state_q) ? '0 : cnt_q + 1'b1;
        // Channels keep trying to rise until each one resolves.
        raise_req = (state_d == ST_ABORT) || (state_d == ST_EXIT);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            en_q      <= '0;
            iso_q     <= 1'b0;
            pwr_q     <= 1'b1;
            save_q    <= 1'b0;
            restore_q <= 1'b0;
            done_q    <= 1'b0;
            denied_q  <= 1'b0;
            tout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            en_q      <= en_d;
            iso_q     <= (state_d == ST_ISO) || (state_d == ST_SAVE) || (state_d == ST_OFF) ||
                         (state_d == ST_PWRUP) || (state_d == ST_RESTORE);
            pwr_q     <= (state_d != ST_OFF);
            save_q    <= (state_d == ST_SAVE);
            restore_q <= (state_d == ST_RESTORE);
            done_q    <= ((state_d == ST_OFF) && (state_q != ST_OFF)) ||
                         ((state_q == ST_EXIT) && (state_d == ST_RUN));
            denied_q  <= (state_q == ST_ABORT) && (state_d == ST_RUN);
            tout_q    <= tout_q | tout_set;
        end
    end

    assign qreqn       = qreqn_v;
    assign iso_en      = iso_q;
    assign pwr_en      = pwr_q;
    assign pr_save     = save_q;
    assign pr_restore  = restore_q;
    assign pm_state    = state_q;
    assign pm_done     = done_q;
    assign pm_denied   = denied_q;
    assign timeout_err = tout_q;

endmodule

// File: tb/tb_qch_pwr_ctrl.sv
// Directed bench for qch_pwr_ctrl: sleep/wake, deny, timeout, partial enable,
// async reset mid-sequence and a stale deny blocking entry.
module tb_qch_pwr_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] ch_en, qreqn, qacceptn, qdeny, pm_state;
    logic       pm_sleep_req, pm_wake_req;
    logic       iso_en, pwr_en, pr_save, pr_restore, pm_done, pm_denied, timeout_err;

    int vecs = 0;
    int errs = 0;

    qch_pwr_ctrl #(.NUM_CH(4), .SAVE_CYCLES(2), .PWRUP_CYCLES(8), .TIMEOUT(16)) dut (
        .clk(clk), .resetn(resetn), .ch_en(ch_en),
        .pm_sleep_req(pm_sleep_req), .pm_wake_req(pm_wake_req),
        .qreqn(qreqn), .qacceptn(qacceptn), .qdeny(qdeny),
        .iso_en(iso_en), .pwr_en(pwr_en), .pr_save(pr_save), .pr_restore(pr_restore),
        .pm_state(pm_state), .pm_done(pm_done), .pm_denied(pm_denied),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        resetn = 1'b0; ch_en = 4'hF; qacceptn = 4'hF; qdeny = 4'h0;
        pm_sleep_req = 1'b0; pm_wake_req = 1'b0;
        step(); step();
        chk("rst_state", 32'(pm_state), 0);
        chk("rst_qreqn", 32'(qreqn), 32'hF);
        chk("rst_pwr",   32'(pwr_en), 1);
        chk("rst_iso",   32'(iso_en), 0);
        chk("rst_tout",  32'(timeout_err), 0);
        chk("rst_done",  32'(pm_done), 0);
        resetn = 1'b1;
        step();

        // Normal sleep / wake, all four channels.
        pm_sleep_req = 1'b1;
        step();
        chk("n_req_qreqn", 32'(qreqn), 0);
        chk("n_req_state", 32'(pm_state), 1);
        pm_sleep_req = 1'b0;
        step(); step();
        qacceptn = 4'h0;
        step();
        chk("n_iso_state", 32'(pm_state), 3);
        chk("n_iso_en",    32'(iso_en), 1);
        chk("n_iso_save",  32'(pr_save), 0);
        step();
        chk("n_save1", 32'(pr_save), 1);
        step();
        chk("n_save2", 32'(pr_save), 1);
        step();
        chk("n_off_state", 32'(pm_state), 5);
        chk("n_off_pwr",   32'(pwr_en), 0);
        chk("n_off_done",  32'(pm_done), 1);
        chk("n_off_save",  32'(pr_save), 0);
        step();
        chk("n_off_done_clr", 32'(pm_done), 0);
        pm_wake_req = 1'b1;
        step();
        chk("n_pwrup_state", 32'(pm_state), 6);
        chk("n_pwrup_pwr",   32'(pwr_en), 1);
        pm_wake_req = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk("n_pwrup_last", 32'(pr_restore), 0);
        step();
        chk("n_restore",       32'(pr_restore), 1);
        chk("n_restore_state", 32'(pm_state), 7);
        step();
        chk("n_exit_state",   32'(pm_state), 8);
        chk("n_exit_restore", 32'(pr_restore), 0);
        chk("n_exit_iso",     32'(iso_en), 0);
        chk("n_exit_qreqn",   32'(qreqn), 32'hF);
        chk("n_exit_done",    32'(pm_done), 0);
        qacceptn = 4'hF;
        step();
        chk("n_run_state", 32'(pm_state), 0);
        chk("n_run_done",  32'(pm_done), 1);

        // Deny: ch0/ch3 accepted, ch1 pending, ch2 denies.
        step();
        pm_sleep_req = 1'b1;
        step();
        pm_sleep_req = 1'b0;
        qacceptn = 4'b0110; qdeny = 4'b0100;
        step();
        chk("d_abort_state", 32'(pm_state), 2);
        chk("d_abort_qreqn", 32'(qreqn), 32'b1101);
        chk("d_abort_pwr",   32'(pwr_en), 1);
        qacceptn = 4'hF; qdeny = 4'h0;
        step();
        chk("d_hold_qreqn", 32'(qreqn), 32'b1101);
        chk("d_hold_state", 32'(pm_state), 2);
        chk("d_hold_iso",   32'(iso_en), 0);
        qacceptn = 4'b1101;
        step();
        chk("d_ch1_qreqn", 32'(qreqn), 32'hF);
        chk("d_ch1_state", 32'(pm_state), 2);
        qacceptn = 4'hF;
        step();
        chk("d_run_state",  32'(pm_state), 0);
        chk("d_run_denied", 32'(pm_denied), 1);
        chk("d_run_pwr",    32'(pwr_en), 1);
        step();
        chk("d_denied_clr", 32'(pm_denied), 0);

        // Timeout with ch3 silent.
        pm_sleep_req = 1'b1;
        step();
        pm_sleep_req = 1'b0;
        qacceptn = 4'b1000;
        for (int i = 0; i < 15; i++) step();
        chk("t_req16_state", 32'(pm_state), 1);
        chk("t_req16_tout",  32'(timeout_err), 0);
        step();
        chk("t_abort_state", 32'(pm_state), 2);
        chk("t_abort_tout",  32'(timeout_err), 1);
        chk("t_abort_qreqn", 32'(qreqn), 32'b0111);
        qacceptn = 4'hF;
        for (int i = 0; i < 22; i++) step();
        chk("t_wait_qreqn", 32'(qreqn), 32'b0111);
        chk("t_wait_state", 32'(pm_state), 2);
        qacceptn = 4'b0111;
        step();
        chk("t_ch3_qreqn", 32'(qreqn), 32'hF);
        qacceptn = 4'hF;
        step();
        chk("t_run_state",  32'(pm_state), 0);
        chk("t_run_denied", 32'(pm_denied), 1);
        chk("t_run_tout",   32'(timeout_err), 1);

        // Partial enable: ch1/ch3 never requested, garbage on their inputs.
        ch_en = 4'b0101;
        pm_sleep_req = 1'b1;
        step();
        chk("p_req_qreqn", 32'(qreqn), 32'b1010);
        pm_sleep_req = 1'b0;
        qacceptn = 4'b1010; qdeny = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("p_entry_qreqn", 32'(qreqn), 32'b1010);
        end
        chk("p_off_state", 32'(pm_state), 5);
        pm_wake_req = 1'b1;
        step();
        pm_wake_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("p_wake_qreqn", 32'(qreqn & 4'b1010), 32'b1010);
        end
        chk("p_restore_state", 32'(pm_state), 7);
        step();
        chk("p_exit_qreqn", 32'(qreqn), 32'hF);
        qacceptn = 4'hF; qdeny = 4'h0;
        step();
        chk("p_run_state", 32'(pm_state), 0);
        chk("p_run_done",  32'(pm_done), 1);

        // Async reset while in SAVE.
        ch_en = 4'hF;
        pm_sleep_req = 1'b1;
        step();
        pm_sleep_req = 1'b0;
        qacceptn = 4'h0;
        step(); step();
        chk("r_save", 32'(pr_save), 1);
        #2 resetn = 1'b0;
        #1;
        chk("r_qreqn", 32'(qreqn), 32'hF);
        chk("r_pwr",   32'(pwr_en), 1);
        chk("r_iso",   32'(iso_en), 0);
        chk("r_save0", 32'(pr_save), 0);
        chk("r_state", 32'(pm_state), 0);
        chk("r_tout",  32'(timeout_err), 0);
        qacceptn = 4'hF;
        #2 resetn = 1'b1;
        step();

        // Stale deny on ch1 blocks entry until it drops.
        qdeny = 4'b0010;
        pm_sleep_req = 1'b1;
        step();
        chk("s_blk1_state", 32'(pm_state), 0);
        chk("s_blk1_qreqn", 32'(qreqn), 32'hF);
        step();
        chk("s_blk2_state", 32'(pm_state), 0);
        qdeny = 4'h0;
        step();
        chk("s_go_state", 32'(pm_state), 1);
        chk("s_go_qreqn", 32'(qreqn), 0);
        pm_sleep_req = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/qch_pwr_ctrl.md
Name: qch_pwr_ctrl

Overview:
Controller-side Q-channel power sequencer for NUM_CH retention-capable devices, e.g. picorv32_qchannel_test instances. It drives qreqn to each device and collects qacceptn/qdeny. On an all-accept it runs the isolate -> save -> power-off sequence; on wake it runs power-up -> restore -> release. Any deny or timeout aborts the request with a per-channel legal roll-back; partial entry never occurs.

Parameters:
NUM_CH, 4, number of Q-channels (1..32)
SAVE_CYCLES, 2, width of pr_save pulse in cycles (>=1)
PWRUP_CYCLES, 8, cycles from pwr_en rising to pr_restore (>=1)
TIMEOUT, 1024, maximum cycles in REQ before abort; 0 disables
CNT_W, $clog2(max(SAVE_CYCLES,PWRUP_CYCLES,TIMEOUT)+1), counter width (derived)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
ch_en  in  NUM_CH  channel participates; sampled on RUN->REQ
pm_sleep_req  in  1  level; sampled only in RUN
pm_wake_req  in  1  level; sampled only in OFF
qreqn  out  NUM_CH  Q-channel request, active-low
qacceptn  in  NUM_CH  device accept, active-low
qdeny  in  NUM_CH  device deny
iso_en  out  1  output isolation enable
pwr_en  out  1  domain power switch enable
pr_save  out  1  retention save strobe
pr_restore  out  1  retention restore strobe, 1 cycle
pm_state  out  4  current FSM state encoding
pm_done  out  1  1-cycle pulse: entered OFF, or returned to RUN after wake
pm_denied  out  1  1-cycle pulse: returned to RUN after an abort
timeout_err  out  1  sticky; cleared only by reset

Behaviour:
- Reset (async, immediate): state=RUN, qreqn=all 1, pwr_en=1, iso_en=0, pr_save=0, pr_restore=0, pm_done=0, pm_denied=0, timeout_err=0, counter=0, en_q=0.
- All outputs are registered. En = en_q. Per channel i: run_i = qacceptn&!qdeny; acc_i = !qacceptn&!qdeny; den_i = qdeny.
- RUN: if pm_sleep_req and all channels in ch_en are run_i, then en_q<=ch_en, qreqn[i]<=0 for en channels, go to REQ. Otherwise stay in RUN.
- REQ: counter increments.
  - If all En are acc_i (vacuously true when En=0), go to ISO.
  - Else if any En den_i, or (TIMEOUT!=0 and counter==TIMEOUT-1), go to ABORT. On timeout also set timeout_err=1.
  - Deny takes priority over the simultaneous timeout flag.
- ABORT: qreqn[i] rises only when qacceptn[i]==qdeny[i]. Each channel is held low until it resolves (accept or deny), then raised.
  - When all En are run_i and qreqn all 1, go to RUN and pulse pm_denied.
  - pwr_en, iso_en and pr_* stay inactive throughout ABORT.
- ISO: iso_en<=1. After 1 cycle go to SAVE.
- SAVE: pr_save=1 for exactly SAVE_CYCLES cycles, then go to OFF.
- OFF: pwr_en<=0; pm_done pulses on entry. On pm_wake_req go to PWRUP.
- PWRUP: pwr_en<=1; wait PWRUP_CYCLES, then go to RESTORE.
- RESTORE: pr_restore=1 for exactly 1 cycle, then go to EXIT.
- EXIT: iso_en<=0, qreqn[i]<=1 for En. When all En are run_i, go to RUN and pulse pm_done.
- Disabled channels: qreqn stays 1 always; their inputs are ignored.
- pm_wake_req outside OFF and pm_sleep_req outside RUN are ignored; they are not latched.
- pm_state encoding: RUN=0, REQ=1, ABORT=2, ISO=3, SAVE=4, OFF=5, PWRUP=6, RESTORE=7, EXIT=8. Unused encodings recover to RUN.
- Counter clears on every state change.

Decomposition:
- qch_pkg: state enum and encodings, and the ch_status helper (run/acc/den).
- Sub-module qch_chan, generated NUM_CH times. It owns its qreqn flop with the legal-transition rule: lower only when run; raise only when qacceptn==qdeny. It reports its status to the top FSM.

Test Plan:
- Normal cycle, 4 channels enabled, each accepts 3 cycles after qreqn falls:
  - qreqn=0000 the cycle after pm_sleep_req.
  - After the last accept: iso_en=1, then pr_save high for 2 cycles, then pwr_en=0 with a pm_done pulse.
  - On wake: pwr_en=1; 8 cycles later pr_restore for 1 cycle; iso_en=0, qreqn=1111; pm_done pulses when all qacceptn=1.
- Deny: ch0 accepted, ch1 pending, ch2 denies.
  - ch0 and ch2 qreqn rise next cycle; ch1 stays low until it accepts, then rises.
  - pm_denied pulses on return to RUN; pwr_en stays 1 throughout.
- Timeout, TIMEOUT=16, ch3 silent:
  - After 16 REQ cycles timeout_err=1 and state=ABORT.
  - ch3 qreqn stays 0 until ch3 accepts at cycle 40, then rises; RUN is reached with pm_denied, and timeout_err stays 1.
- ch_en=0101: only qreqn[0] and qreqn[2] toggle; qreqn[1] and qreqn[3] stay 1 for the whole sleep/wake cycle.
- Async reset asserted during SAVE: the same cycle shows qreqn=1111, pwr_en=1, iso_en=0, pr_save=0 and pm_state=0.
- pm_sleep_req while ch1 qdeny is still 1 from a prior deny: the FSM stays in RUN until qdeny falls, then enters REQ.
